// File: rtl/transpose_tile_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : transpose_pkg
//  Purpose  : Shared types and width helpers for the transpose tile buffer.
//  Revision : 1.0  initial release
// ============================================================================
package transpose_pkg;

  typedef enum logic {MODE_PASS, MODE_TRANSPOSE} tmode_t;

  // Width of a row/lane index counting 0..n-1.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a row count 0..n.
  function automatic int rows_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/transpose_tile_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : transpose_tile_buffer_if
//  Purpose  : Row stream in / row stream out handshake bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface transpose_tile_buffer_if #(
  parameter int N = 8,
  parameter int W = 32
);
  localparam int c_rw = transpose_pkg::rows_width(N);

  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
  logic             in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N*W-1:0]   out_data;
  logic             out_last;
  logic             out_mode;
  logic [c_rw-1:0]  out_rows;

  // Producer/consumer side (drives rows in, accepts rows out).
  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_mode, out_rows
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_mode, out_rows
  );
endinterface
`default_nettype wire

// File: rtl/transpose_tile_buffer_tile_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tile_bank
//  Purpose  : One N x N tile store with a row write port and a combinational
//             row read port that applies PASS/TRANSPOSE and zero padding.
//  Revision : 1.0  initial release
// ============================================================================
module tile_bank
  import transpose_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [idx_width(N)-1:0]        wr_row,
  input  logic [N*W-1:0]                 wr_data,
  input  logic [idx_width(N)-1:0]        rd_row,
  input  tmode_t                         rd_mode,
  input  logic [rows_width(N)-1:0]       rd_rows,
  output logic [N*W-1:0]                 rd_data
);

  logic [W-1:0] r_mem [N][N];

  // Row write; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < N; c++) begin
        r_mem[wr_row][c] <= wr_data[c*W +: W];
      end
    end
  end

  // Row read: rows beyond the written count are treated as zero.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N; c++) begin
      if (rd_mode == MODE_TRANSPOSE) begin
        if (c < int'(rd_rows)) rd_data[c*W +: W] = r_mem[c][rd_row];
      end else begin
        if (int'(rd_row) < int'(rd_rows)) rd_data[c*W +: W] = r_mem[rd_row][c];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/transpose_tile_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : transpose_tile_buffer
//  Purpose  : Double-buffered N x N tile buffer replaying tiles as written or
//             transposed, with ready/valid flow control on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module transpose_tile_buffer
  import transpose_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  transpose_tile_buffer_if.slave  bus
);

  localparam int CW = idx_width(N);
  localparam int RW = rows_width(N);
  localparam logic [CW-1:0] c_last_row = CW'(N - 1);

  logic [1:0]    r_full;
  tmode_t        r_mode [2];
  logic [RW-1:0] r_rows [2];
  logic          r_wr_sel;
  logic          r_rd_sel;
  logic [CW-1:0] r_wr_row;
  logic [CW-1:0] r_rd_row;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_accept;
  logic          w_close;
  logic          w_fire;
  logic [N*W-1:0] w_bank_data [2];

  assign w_in_ready  = enable & ~r_full[r_wr_sel];
  assign w_out_valid = enable & r_full[r_rd_sel];
  assign w_accept    = w_in_ready & bus.in_valid;
  assign w_close     = w_accept & ((r_wr_row == c_last_row) | bus.in_last);
  assign w_fire      = w_out_valid & bus.out_ready;

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      tile_bank #(.N(N), .W(W)) u_bank (
        .clk     (clk),
        .we      (w_accept && (r_wr_sel == 1'(b))),
        .wr_row  (r_wr_row),
        .wr_data (bus.in_data),
        .rd_row  (r_rd_row),
        .rd_mode (r_mode[b]),
        .rd_rows (r_rows[b]),
        .rd_data (w_bank_data[b])
      );
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_bank_data[r_rd_sel] : '0;
  assign bus.out_last  = w_out_valid & (r_rd_row == c_last_row);
  assign bus.out_mode  = w_out_valid & (r_mode[r_rd_sel] == MODE_TRANSPOSE);
  assign bus.out_rows  = w_out_valid ? r_rows[r_rd_sel] : '0;

  // Write/read progress, bank ownership and full flags. A close and a free
  // in the same cycle always target different banks, so both apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full   <= '0;
      r_mode[0] <= MODE_PASS;
      r_mode[1] <= MODE_PASS;
      r_rows[0] <= '0;
      r_rows[1] <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_row <= '0;
      r_rd_row <= '0;
    end else begin
      if (w_accept) begin
        if (r_wr_row == '0) r_mode[r_wr_sel] <= tmode_t'(bus.in_mode);
        if (w_close) begin
          r_full[r_wr_sel] <= 1'b1;
          r_rows[r_wr_sel] <= RW'(r_wr_row) + RW'(1);
          r_wr_row         <= '0;
          r_wr_sel         <= ~r_wr_sel;
        end else begin
          r_wr_row <= r_wr_row + CW'(1);
        end
      end
      if (w_fire) begin
        if (r_rd_row == c_last_row) begin
          r_full[r_rd_sel] <= 1'b0;
          r_rd_row         <= '0;
          r_rd_sel         <= ~r_rd_sel;
        end else begin
          r_rd_row <= r_rd_row + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transpose_tile_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_transpose_tile_buffer
//  Purpose  : Self-checking bench for transpose_tile_buffer (N=8, W=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_transpose_tile_buffer;

  localparam int N = 8;
  localparam int W = 32;

  typedef struct packed {
    logic [N-1:0][N*W-1:0] o;     // expected output rows, already padded/transposed
    logic                  mode;
    logic [3:0]            rows;
  } tile_t;

  logic clk = 1'b0;
  logic reset;
  logic en;

  transpose_tile_buffer_if #(.N(N), .W(W)) bus ();

  transpose_tile_buffer #(.N(N), .W(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  // Reference model: queue of completed tiles plus the tile being written.
  tile_t          q[$];
  logic [N*W-1:0] cur [N];
  int             cnt = 0;
  logic           cur_mode = 1'b0;
  int             rd = 0;
  bit             chk_zero = 0;
  bit             last_accept = 0;

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] mkrow(input bit pat, input int r);
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = pat ? 32'(r*16 + c) : $urandom();
    return v;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic step();
    logic er, ev, acc, fire;
    tile_t t;
    logic [N*W-1:0] p [N];
    @(negedge clk);
    er = en & (q.size() < 2);
    ev = en & (q.size() > 0);
    check("in_ready", bus.in_ready, er);
    check("out_valid", bus.out_valid, ev);
    if (ev) begin
      check("out_data", bus.out_data, q[0].o[rd]);
      check("out_last", bus.out_last, (rd == N-1));
      check("out_mode", bus.out_mode, q[0].mode);
      check("out_rows", bus.out_rows, q[0].rows);
    end else begin
      check("out_data_idle", bus.out_data, '0);
    end
    if (chk_zero) begin
      check("rst_out_last", bus.out_last, 1'b0);
      check("rst_out_mode", bus.out_mode, 1'b0);
      check("rst_out_rows", bus.out_rows, '0);
      chk_zero = 0;
    end
    acc  = er & bus.in_valid;
    fire = ev & bus.out_ready;
    last_accept = acc && !reset;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      cnt = 0;
      rd = 0;
      chk_zero = 1;
    end else begin
      if (fire) begin
        rd++;
        if (rd == N) begin
          void'(q.pop_front());
          rd = 0;
        end
      end
      if (acc) begin
        if (cnt == 0) cur_mode = bus.in_mode;
        cur[cnt] = bus.in_data;
        cnt++;
        if (cnt == N || bus.in_last) begin
          for (int r = 0; r < N; r++) p[r] = (r < cnt) ? cur[r] : '0;
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              t.o[r][c*W +: W] = cur_mode ? p[c][r*W +: W] : p[r][c*W +: W];
          t.mode = cur_mode;
          t.rows = 4'(cnt);
          q.push_back(t);
          cnt = 0;
        end
      end
    end
  endtask

  task automatic send_tile(input logic mode, input int nrows, input bit pat, input bit lst);
    int r = 0;
    int guard = 0;
    logic [N*W-1:0] row;
    row = mkrow(pat, 0);
    while (r < nrows && guard < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row;
      bus.in_mode  = mode;
      bus.in_last  = lst && (r == nrows - 1);
      step();
      guard++;
      if (last_accept) begin
        r++;
        row = mkrow(pat, r);
      end
    end
    bus.in_last = 1'b0;
    check("send_rows_accepted", 256'(r), 256'(nrows));
  endtask

  task automatic drain();
    int guard = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() > 0 && guard < 100) begin
      step();
      guard++;
    end
    check("drain_empty", 256'(q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 1'b1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_mode = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // PASS then TRANSPOSE with the r*16+c pattern
    bus.out_ready = 1'b1;
    send_tile(1'b0, 8, 1'b1, 1'b1);
    drain();
    send_tile(1'b1, 8, 1'b1, 1'b1);
    drain();

    // Back-to-back tiles, alternating mode, in_valid held high
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) send_tile(1'(t % 2), 8, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: two tiles fill the buffer, a third waits
    bus.out_ready = 1'b0;
    send_tile(1'b0, 8, 1'b0, 1'b0);
    send_tile(1'b1, 8, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = mkrow(1'b0, 0);
    for (int i = 0; i < 4; i++) step();
    bus.out_ready = 1'b1;
    send_tile(1'b0, 8, 1'b0, 1'b0);
    drain();

    // Short transposed tile
    send_tile(1'b1, 3, 1'b0, 1'b1);
    drain();

    // Reset after four rows, then a full tile
    send_tile(1'b0, 4, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    send_tile(1'b0, 8, 1'b0, 1'b1);
    drain();

    // Enable low mid-replay
    send_tile(1'b1, 8, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en = 1'b1;
    drain();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      en            = ($urandom_range(0, 9) != 0);
      reset         = ($urandom_range(0, 149) == 0);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      bus.in_data   = mkrow(1'b0, 0);
      bus.in_mode   = 1'($urandom_range(0, 1));
      bus.in_last   = ($urandom_range(0, 5) == 0);
      step();
    end
    en = 1'b1;
    reset = 1'b0;
    bus.in_last = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/transpose_tile_buffer.md
# transpose_tile_buffer

Parametrised, double-buffered N×N tile buffer. Accepts a tile one row per beat and replays it either unchanged or transposed, with ready/valid flow control on both sides. Ping-pong banks sustain one row per cycle in each direction. Short tiles are zero-padded. Sits between the systolic multiplier array and the accumulate/write-back path, feeding row- or column-ordered operands.

## Interface
- N, default 8: tile dimension (rows = lanes); N ≥ 2
- W, default 32: element width in bits
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  global advance; low = freeze all state, in_ready=0, out_valid=0
- in_valid  in  1  in_data row valid
- in_ready  out  1  buffer can accept a row
- in_data  in  N*W  one row; lane c at bits [c*W +: W]
- in_mode  in  1  tile mode, sampled on first beat of a tile: 0=PASS, 1=TRANSPOSE
- in_last  in  1  last row of tile; may close tile before N rows
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts row
- out_data  out  N*W  output row; lane layout as in_data; 0 when out_valid=0
- out_last  out  1  high on output row N-1
- out_mode  out  1  mode of tile being replayed
- out_rows  out  $clog2(N+1)  number of input rows written to the current tile (1..N)

## Operation
- Accept = enable & in_valid & in_ready. Fire = enable & out_valid & out_ready.
- Two banks B0/B1, each with N×N×W data, full flag, mode bit and row count. wr_sel, rd_sel and wr_row/rd_row counters track progress.
- **Write side**
  - in_ready = enable & ~full[wr_sel].
  - On accept: store the row at wr_row. On wr_row==0, latch in_mode.
  - Tile closes when wr_row==N-1 or in_last. On close: full[wr_sel]←1, rows←wr_row+1, wr_row←0, wr_sel toggles.
  - in_last on row N-1 is a normal close.
- **Read side**
  - out_valid = enable & full[rd_sel].
  - Output row r, lane c:
    - PASS: mem[r][c].
    - TRANSPOSE: mem[c][r].
    - Any element whose source row index ≥ rows reads 0.
  - Replay is always N rows regardless of rows.
  - On fire with rd_row==N-1: full[rd_sel]←0, rd_row←0, rd_sel toggles. Otherwise rd_row++.
- Full flags are registered. A bank freed in cycle t is writable from t+1; no same-cycle write-through.
- Close and free in the same cycle on different banks are both honoured.
- Data registers are not reset. All flags, counters and selects are reset.

## Timing
- Reset values: in_ready=1 (when enable=1), out_valid=0, out_data=0, out_last=0, out_mode=0, out_rows=0 (valid only when out_valid). wr_sel=rd_sel=0, wr_row=rd_row=0, full=00.
- Latency: the tile's first output row is valid the cycle after its closing row is accepted.
- Throughput: with out_ready held high, 1 row/cycle sustained indefinitely; in_ready never drops.
- Backpressure:
  - With out_ready=0, at most 2 tiles are buffered, then in_ready=0.
  - out_data, out_last, out_mode and out_rows hold stable while out_valid & ~out_ready.
- Reset mid-tile discards both banks; the next cycle behaves as after reset.
- enable=0 holds every register; handshake outputs are masked low.

## Structure
- Package transpose_pkg:
  - typedef enum logic {MODE_PASS, MODE_TRANSPOSE} tmode_t
  - function clog2-based width for rows/counters
- Sub-module tile_bank (parameters N, W):
  - N×N storage
  - row write port (we, row index, data)
  - combinational read port (row index, mode, rows) implementing the PASS/TRANSPOSE mux and zero masking
- Two tile_bank instances. Control (selects, counters, flags) stays in transpose_tile_buffer.

## Test plan
- **PASS, full tile:** N=8, W=32, out_ready=1; element (r,c)=r*16+c, in_mode=0.
  - Output rows equal input rows.
  - out_last on the 8th row; first out_valid one cycle after the 8th accept; out_rows=8.
- **TRANSPOSE:** same stimulus with in_mode=1.
  - Output row r lane c = c*16+r; out_mode=1.
- **Back-to-back:** 3 tiles with alternating mode, in_valid and out_ready held 1.
  - in_ready never drops.
  - 24 contiguous output beats; each tile uses its own mode.
- **Backpressure:** out_ready=0.
  - in_ready drops after exactly 16 accepts; out_data stable.
  - out_ready=1 releases tile 0, then tile 1.
  - in_ready rises the cycle after tile 0's last fire.
- **Short tile:** in_last on the 3rd row, TRANSPOSE.
  - out_rows=3; all 8 rows replayed.
  - Lanes 3..7 = 0 in every output row.
- **Reset / enable:**
  - reset asserted after 4 rows accepted: next cycle out_valid=0, in_ready=1, and the next full tile outputs correctly.
  - enable=0 for 5 cycles mid-replay: no progress, outputs masked; replay resumes at the same row.
